addn_reduce: RTL and testbench
==============================

// Module: addn_reduce
// PURPOSE
// Parametrised multi-operand adder with a scheduled reduction. Loads N_IN operands on a start
// strobe, then sums them over several cycles using N_ADD shared adders working at ACC_W bits.
// Signals completion with w_enable/result and holds the result until the next start.
// Generalises the fixed 7-input, 2-adder sum kernel: adds wrap/saturate modes, an overflow flag and abort/restart.
// PARAMETERS
// N_IN    7   number of operands (>=1)
// N_ADD   2   adders usable per cycle (>=1)
// DATA_W  64  operand/result port width
// ACC_W   13  arithmetic width (1..DATA_W); operands truncated to ACC_W bits at load
// PORTS
// clk       in   1              clock, all logic on posedge
// rst       in   1              synchronous active-high reset
// r_enable  in   1              start strobe: latch operands, begin reduction
// sat_en    in   1              1 = saturating adds, 0 = wrap mod 2^ACC_W; sampled with r_enable
// init_vec  in   N_IN*DATA_W    operand i at init_vec[i*DATA_W +: DATA_W]
// busy      out  1              reduction in progress
// w_enable  out  1              result valid; held until next r_enable or rst
// result    out  DATA_W         sum, zero-extended from ACC_W bits
// ovf       out  1              at least one add carried out of ACC_W during this run
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, busy=0, w_enable=0, result=0, ovf=0, cnt=0.
//   rst dominates r_enable. rst mid-run aborts with no w_enable pulse.
// - States: IDLE, REDUCE, DONE. A sampled r_enable in ANY state (rst=0) does all of:
//   opr[i] <= init_vec operand i [ACC_W-1:0]; cnt <= N_IN; sat <= sat_en; ovf <= 0;
//   w_enable <= 0; result is left unchanged. Next state: REDUCE (busy=1), or DONE if N_IN==1.
// - In DONE for N_IN==1: the edge after load sets w_enable=1, result=opr[0].
// - REDUCE step, one per edge: p = min(N_ADD, floor(cnt/2)).
//   For k<p: new opr[k] = opr[2k] (+) opr[2k+1].
//   Unpaired opr[2p..cnt-1] shift down to index p onward, order kept. cnt <= cnt-p.
// - (+) is computed in ACC_W+1 bits. If the carry bit is set, ovf <= 1 (sticky for the run).
//   The stored value is sum mod 2^ACC_W when sat=0, or 2^ACC_W-1 when sat=1.
// - On the edge where new cnt==1: state <= DONE, busy <= 0, w_enable <= 1,
//   result <= {zero-extend, new opr[0]} (same edge, no extra cycle).
// - DONE holds w_enable, result and ovf stable indefinitely. IDLE and DONE ignore everything except r_enable and rst.
// - Latency (r_enable edge to the w_enable=1 edge) = number of REDUCE steps.
//   Examples: 7/2 -> 4 (7,5,3,2,1); 7/3 -> 3; 8/4 -> 3; 2/1 -> 1.
// - r_enable during REDUCE: abort and restart from the new operands; the old run never asserts w_enable.
// - r_enable in the same cycle that the old run would finish: the restart wins, and w_enable stays 0.
// - Unused opr slots (index >= cnt) are don't-care and must not affect result or ovf.
// - Adder inputs are muxed by the step pattern. The number of adder instances is exactly N_ADD.
// TESTING
// 1. Defaults, operands 1..7, sat_en=0 -> busy for 4 cycles. The 4th edge after r_enable gives w_enable=1, result=28, ovf=0.
// 2. Defaults, all operands 8191, sat_en=0 -> result=8185 (57337 mod 8192), ovf=1, latency 4.
// 3. Same as 2 with sat_en=1 -> result=8191, ovf=1.
// 4. Truncation: op0=64'h1_0000_0001, op1=64'h2000, rest 0 -> result=1 (bit 13 and up dropped), ovf=0.
// 5. Restart: load 1..7, r_enable again at the 2nd REDUCE edge with all ops=10.
//    -> no w_enable before it, then result=70 on the 4th edge after the 2nd r_enable.
// 6. rst at the 2nd REDUCE edge -> busy=0, w_enable=0, result=0 afterwards. Also N_ADD=3 build: ops 1..7 -> result=28 at latency 3.

Source files
------------

// File: rtl/addn_reduce.sv
// Multi-operand adder: latches N_IN operands on r_enable and reduces them pairwise
// with N_ADD shared ACC_W-bit adders, one reduction step per clock.
module addn_reduce #(
  parameter int N_IN   = 7,
  parameter int N_ADD  = 2,
  parameter int DATA_W = 64,
  parameter int ACC_W  = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_enable,
  input  logic                     sat_en,
  input  logic [N_IN*DATA_W-1:0]   init_vec,
  output logic                     busy,
  output logic                     w_enable,
  output logic [DATA_W-1:0]        result,
  output logic                     ovf
);

  localparam int CNT_W = $clog2(N_IN + 1);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    opr_q [N_IN];
  logic [ACC_W-1:0]    opr_d [N_IN];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                busy_q, busy_d;
  logic                wen_q, wen_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   result_q, result_d;
  int                  step_p;

  logic [ACC_W-1:0]    pair_val [N_IN];
  logic                pair_cy  [N_IN];
  logic                unused_init_hi;

  // Operand bits above ACC_W are dropped at load.
  assign unused_init_hi = ^init_vec;

  // Adder j always combines slots 2j and 2j+1; the step only decides which results are kept.
  for (genvar j = 0; j < N_IN; j++) begin : g_pair
    if (j < N_ADD && 2*j + 1 < N_IN) begin : g_add
      logic [ACC_W:0] sum;
      assign sum         = {1'b0, opr_q[2*j]} + {1'b0, opr_q[2*j+1]};
      assign pair_cy[j]  = sum[ACC_W];
      assign pair_val[j] = (sum[ACC_W] && sat_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end else begin : g_none
      assign pair_cy[j]  = 1'b0;
      assign pair_val[j] = '0;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    opr_d    = opr_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    busy_d   = busy_q;
    wen_d    = wen_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    step_p   = (int'(cnt_q) / 2 < N_ADD) ? int'(cnt_q) / 2 : N_ADD;

    if (r_enable) begin
      for (int i = 0; i < N_IN; i++) opr_d[i] = init_vec[i*DATA_W +: ACC_W];
      cnt_d = CNT_W'(N_IN);
      sat_d = sat_en;
      ovf_d = 1'b0;
      wen_d = 1'b0;
      if (N_IN == 1) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
      end else begin
        state_d = S_REDUCE;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        S_REDUCE: begin
          // NOTE: blocking assignments here let opr_d/cnt_d be read back within the same step.
          for (int j = 0; j < N_IN; j++) begin
            if (j < step_p) begin
              opr_d[j] = pair_val[j];
              if (pair_cy[j]) ovf_d = 1'b1;
            end else if (j + step_p < N_IN) begin
              opr_d[j] = opr_q[IDX_W'(j + step_p)];
            end
          end
          cnt_d = cnt_q - CNT_W'(step_p);
          if (cnt_d == CNT_W'(1)) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            wen_d    = 1'b1;
            result_d = DATA_W'(opr_d[0]);
          end
        end
        S_DONE: begin
          // Only reached with w_enable low when a single operand skipped REDUCE.
          if (!wen_q) begin
            wen_d    = 1'b1;
            result_d = DATA_W'(opr_q[0]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      wen_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  // NOTE: operand storage is not reset; state and cnt keep stale contents from being used.
  always_ff @(posedge clk) begin
    opr_q <= opr_d;
  end

  assign busy     = busy_q;
  assign w_enable = wen_q;
  assign result   = result_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_addn_reduce.sv
// Self-checking bench for addn_reduce: N_ADD=2 and N_ADD=3 builds share one stimulus stream
// and are compared every cycle against a queue-based model of the reduction schedule.
module tb_addn_reduce;

  localparam int N_IN   = 7;
  localparam int DATA_W = 64;
  localparam int ACC_W  = 13;
  localparam int LIM    = 1 << ACC_W;

  typedef struct packed {
    logic        busy;
    logic        wen;
    logic        ovf;
    logic [63:0] result;
    logic [63:0] pend;
    logic [7:0]  hist;
    int          step;
    int          steps;
  } model_t;

  logic                    clk;
  logic                    rst;
  logic                    r_enable;
  logic                    sat_en;
  logic [N_IN*DATA_W-1:0]  init_vec;
  logic                    busy2, wen2, ovf2, busy3, wen3, ovf3;
  logic [DATA_W-1:0]       result2, result3;

  model_t m2, m3;
  logic   cmp_en;
  int     n_checks;
  int     n_errors;
  int     lat2, lat3;

  addn_reduce #(.N_IN(N_IN), .N_ADD(2), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut2 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .sat_en(sat_en), .init_vec(init_vec),
    .busy(busy2), .w_enable(wen2), .result(result2), .ovf(ovf2)
  );

  addn_reduce #(.N_IN(N_IN), .N_ADD(3), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut3 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .sat_en(sat_en), .init_vec(init_vec),
    .busy(busy3), .w_enable(wen3), .result(result3), .ovf(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reduction modelled on a list of values: take up to n_add pairs from the front,
  // keep the leftovers in order, repeat until one value remains.
  function automatic model_t model_step(input model_t m, input logic rst_i, input logic ren,
                                        input logic sat, input logic [N_IN*DATA_W-1:0] vec,
                                        input int n_add);
    model_t n;
    int     vals[$];
    int     nv[$];
    int     p;
    int     s;
    logic   cum;
    n = m;
    if (rst_i) begin
      n = '0;
    end else if (ren) begin
      vals = {};
      for (int i = 0; i < N_IN; i++) vals.push_back(int'(vec[i*DATA_W +: DATA_W] % LIM));
      cum     = 1'b0;
      n.steps = 0;
      n.hist  = '0;
      while (vals.size() > 1) begin
        p = vals.size() / 2;
        if (p > n_add) p = n_add;
        nv = {};
        for (int k = 0; k < p; k++) begin
          s = vals[2*k] + vals[2*k+1];
          if (s >= LIM) begin
            cum = 1'b1;
            s   = sat ? LIM - 1 : s - LIM;
          end
          nv.push_back(s);
        end
        for (int k = 2*p; k < vals.size(); k++) nv.push_back(vals[k]);
        vals            = nv;
        n.hist[n.steps] = cum;
        n.steps++;
      end
      n.pend = 64'(vals[0]);
      n.busy = (n.steps > 0);
      n.wen  = 1'b0;
      n.ovf  = 1'b0;
      n.step = 0;
    end else if (m.busy) begin
      n.ovf  = m.hist[m.step];
      n.step = m.step + 1;
      if (n.step == m.steps) begin
        n.busy   = 1'b0;
        n.wen    = 1'b1;
        n.result = m.pend;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m2 <= model_step(m2, rst, r_enable, sat_en, init_vec, 2);
    m3 <= model_step(m3, rst, r_enable, sat_en, init_vec, 3);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy_n2",   busy2,   m2.busy);
      check("wen_n2",    wen2,    m2.wen);
      check("result_n2", result2, m2.result);
      check("ovf_n2",    ovf2,    m2.ovf);
      check("busy_n3",   busy3,   m3.busy);
      check("wen_n3",    wen3,    m3.wen);
      check("result_n3", result3, m3.result);
      check("ovf_n3",    ovf3,    m3.ovf);
    end
  end

  function automatic logic [N_IN*DATA_W-1:0] fill(input logic [63:0] base, input logic [63:0] inc);
    logic [N_IN*DATA_W-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*DATA_W +: DATA_W] = base + inc * 64'(i);
    return v;
  endfunction

  // Called just after a falling edge; r_enable is sampled on the next rising edge.
  task automatic drive_start(input logic [N_IN*DATA_W-1:0] vec, input logic sat);
    init_vec = vec;
    sat_en   = sat;
    r_enable = 1'b1;
    @(negedge clk);
    r_enable = 1'b0;
  endtask

  // Cycles from the load edge to the first w_enable of each build; 0 means it never came.
  task automatic wait_done(output int l2, output int l3);
    l2 = 0;
    l3 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wen2 && l2 == 0) l2 = i;
      if (wen3 && l3 == 0) l3 = i;
    end
  endtask

  initial begin
    logic [N_IN*DATA_W-1:0] v;
    n_checks = 0;
    n_errors = 0;
    cmp_en   = 1'b0;
    rst      = 1'b1;
    r_enable = 1'b0;
    sat_en   = 1'b0;
    init_vec = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("reset_busy",   busy2,   0);
    check("reset_wen",    wen2,    0);
    check("reset_result", result2, 0);
    check("reset_ovf",    ovf2,    0);

    drive_start(fill(1, 1), 1'b0);
    wait_done(lat2, lat3);
    check("t1_lat2",    64'(lat2), 4);
    check("t1_lat3",    64'(lat3), 3);
    check("t1_result2", result2,   28);
    check("t1_ovf2",    ovf2,      0);
    check("t1_result3", result3,   28);

    drive_start(fill(8191, 0), 1'b0);
    wait_done(lat2, lat3);
    check("t2_lat2",    64'(lat2), 4);
    check("t2_result2", result2,   8185);
    check("t2_ovf2",    ovf2,      1);
    check("t2_result3", result3,   8185);

    drive_start(fill(8191, 0), 1'b1);
    wait_done(lat2, lat3);
    check("t3_result2", result2, 8191);
    check("t3_ovf2",    ovf2,    1);
    check("t3_result3", result3, 8191);

    v = '0;
    v[0*DATA_W +: DATA_W] = 64'h1_0000_0001;
    v[1*DATA_W +: DATA_W] = 64'h2000;
    drive_start(v, 1'b0);
    wait_done(lat2, lat3);
    check("t4_result2", result2, 1);
    check("t4_ovf2",    ovf2,    0);

    drive_start(fill(1, 1), 1'b0);
    @(negedge clk);
    drive_start(fill(10, 0), 1'b0);
    wait_done(lat2, lat3);
    check("t5_lat2",    64'(lat2), 4);
    check("t5_result2", result2,   70);
    check("t5_result3", result3,   70);

    drive_start(fill(1, 1), 1'b0);
    repeat (3) @(negedge clk);
    drive_start(fill(2, 0), 1'b0);
    check("t5b_wen2", wen2, 0);
    wait_done(lat2, lat3);
    check("t5b_lat2",    64'(lat2), 4);
    check("t5b_result2", result2,   14);

    drive_start(fill(1, 1), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy",   busy2,   0);
    check("t6_wen",    wen2,    0);
    check("t6_result", result2, 0);
    repeat (6) @(negedge clk);
    check("t6_wen_late", wen2, 0);

    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < N_IN; i++) begin
        case ($urandom % 4)
          0:       v[i*DATA_W +: DATA_W] = {$urandom, $urandom};
          1:       v[i*DATA_W +: DATA_W] = 64'($urandom % 16);
          2:       v[i*DATA_W +: DATA_W] = 64'(8191 - ($urandom % 16));
          default: v[i*DATA_W +: DATA_W] = 64'($urandom % 8192);
        endcase
      end
      drive_start(v, 1'($urandom % 2));
      repeat ($urandom % 7) @(negedge clk);
      if ($urandom % 12 == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
